// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 9
) ();
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over a req/ack channel, issues one word at a time.
// Optional FETCH_INSTR_COUNT_EN adds a saturating 16-bit issued-instruction counter port.
module fetch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    fetch_unit_if.master           imem,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    input  logic                   branch,
    input  logic                   branch_cond,
    input  logic                   jmp_ctrl,
    input  logic                   done_ctrl,
    input  logic [PC_WIDTH-1:0]    target_addr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [15:0]            instr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [PC_WIDTH-1:0]    pc_r;
    logic [PC_WIDTH-1:0]    pc_next_s;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic                   req_r;
    logic                   valid_r;
    logic                   halted_r;
    logic                   start_ok_s;

    // Next-state and next-PC selection; control inputs are only looked at in ISSUE.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        start_ok_s   = 1'b0;
        case (state_r)
            IDLE, HALTED: begin
                if (start) begin
                    start_ok_s   = 1'b1;
                    pc_next_s    = {PC_WIDTH{1'b0}};
                    state_next_s = FETCH;
                end else begin
                    state_next_s = state_r;
                end
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            ISSUE: begin
                if (done_ctrl) begin
                    state_next_s = HALTED;
                end else if (jmp_ctrl) begin
                    pc_next_s    = target_addr;
                    state_next_s = FETCH;
                end else if (branch && branch_cond) begin
                    pc_next_s    = target_addr;
                    state_next_s = FETCH;
                end else begin
                    pc_next_s    = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                    state_next_s = FETCH;
                end
            end
            default: begin
                state_next_s = IDLE;
                pc_next_s    = {PC_WIDTH{1'b0}};
            end
        endcase
    end

    // State, PC and output flags; flags are registered from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            pc_r     <= {PC_WIDTH{1'b0}};
            instr_r  <= {INSTR_WIDTH{1'b0}};
            req_r    <= 1'b0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            req_r    <= (state_next_s == FETCH);
            valid_r  <= (state_next_s == ISSUE);
            halted_r <= (state_next_s == HALTED);
            if ((state_r == FETCH) && imem.imem_ack) begin
                instr_r <= imem.imem_rdata;
            end
        end
    end

`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] count_r;

    // Issued-instruction counter, saturating, restarted by an accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 16'h0000;
        end else if (start_ok_s) begin
            count_r <= 16'h0000;
        end else if (valid_r && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'h0001;
        end
    end

    assign instr_count = count_r;
`else
    logic unused_start_ok_s;
    assign unused_start_ok_s = start_ok_s;
`endif

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign instruction    = instr_r;
    assign instr_valid    = valid_r;
    assign pc             = pc_r;
    assign halted         = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory and control-unit models plus an issue scoreboard.
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] instruction;
    logic       instr_valid;
    logic       branch, branch_cond, jmp_ctrl, done_ctrl;
    logic [7:0] target_addr;
    logic [7:0] pc;
    logic       halted;
`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(9)) bus ();

    fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(9)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .imem        (bus),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .branch      (branch),
        .branch_cond (branch_cond),
        .jmp_ctrl    (jmp_ctrl),
        .done_ctrl   (done_ctrl),
        .target_addr (target_addr),
        .pc          (pc),
        .halted      (halted)
`ifdef FETCH_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: per-address wait states, optional ack forced high at all times.
    logic [8:0] mem [256];
    int         wait_at [256];
    logic [3:0] ctl [256];      // {done, jmp, branch, branch_cond}
    logic [7:0] tgt [256];
    logic       ack_force;
    int         wcnt;

    always @(posedge clock) begin
        if (reset || !bus.imem_req || bus.imem_ack) wcnt <= 0;
        else                                        wcnt <= wcnt + 1;
    end

    assign bus.imem_ack   = ack_force | (bus.imem_req && (wcnt >= wait_at[bus.imem_addr]));
    assign bus.imem_rdata = mem[bus.imem_addr];

    // Control-unit model: decode is only meaningful while an instruction is issued.
    always_comb begin
        if (instr_valid) begin
            {done_ctrl, jmp_ctrl, branch, branch_cond} = ctl[pc];
            target_addr = tgt[pc];
        end else begin
            {done_ctrl, jmp_ctrl, branch, branch_cond} = 4'bxxxx;
            target_addr = 8'hxx;
        end
    end

    typedef struct {
        logic [7:0] pc;
        logic [8:0] instr;
        int         reqc;
        int         gap;
    } exp_t;
    exp_t sb[$];

    task automatic expect_issue(input logic [7:0] p, input int reqc, input int gap);
        exp_t e;
        e.pc = p; e.instr = mem[p]; e.reqc = reqc; e.gap = gap;
        sb.push_back(e);
    endtask

    int         req_run = 0;
    int         since_valid = 0;
    logic [7:0] prev_addr;
    exp_t       got;

    // Monitor: handshake stability, then pop and compare each issued instruction.
    always @(negedge clock) begin
        if (reset) begin
            req_run = 0;
            since_valid = 0;
        end else begin
            since_valid++;
            if (bus.imem_req) begin
                chk("addr_eq_pc", 32'(bus.imem_addr), 32'(pc));
                if (req_run > 0) chk("addr_stable", 32'(bus.imem_addr), 32'(prev_addr));
                prev_addr = bus.imem_addr;
                req_run++;
            end
            if (instr_valid) begin
                chk("issue_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("issue_pc", 32'(pc), 32'(got.pc));
                    chk("issue_instr", 32'(instruction), 32'(got.instr));
                    chk("issue_req_cycles", 32'(req_run), 32'(got.reqc));
                    if (got.gap != 0) chk("issue_gap", 32'(since_valid), 32'(got.gap));
                end
                req_run = 0;
                since_valid = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ack_force = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 9'h000; wait_at[i] = 0; ctl[i] = 4'b0000; tgt[i] = 8'h00;
        end
        tick(); tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_INSTR_COUNT_EN
        chk("rst_count", 32'(instr_count), 32'd0);
`endif
        reset = 1'b0;

        // Sequential fetch with ack tied high; halt word has done and jmp together.
        mem[4] = 9'h0E2; ctl[4] = 4'b1100; tgt[4] = 8'h40;
        ack_force = 1'b1;
        tick(); tick();
        chk("idle_ack_ignored_valid", 32'(instr_valid), 32'd0);
        chk("idle_ack_ignored_req", 32'(bus.imem_req), 32'd0);
        expect_issue(8'd0, 1, 0);
        for (int p = 1; p <= 4; p++) expect_issue(8'(p), 1, 2);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_req", 32'(bus.imem_req), 32'd1);
        chk("start_addr", 32'(bus.imem_addr), 32'd0);
        tick(); tick();
        start = 1'b1; tick(); tick(); start = 1'b0;
        wait_drain(40);
        tick();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd4);
        chk("halt_instr", 32'(instruction), 32'h0E2);
        chk("halt_req", 32'(bus.imem_req), 32'd0);
`ifdef FETCH_INSTR_COUNT_EN
        chk("count_five", 32'(instr_count), 32'd5);
`endif
        tick(); tick(); tick();
        chk("halt_hold_pc", 32'(pc), 32'd4);
        chk("halt_hold_flag", 32'(halted), 32'd1);
`ifdef FETCH_INSTR_COUNT_EN
        chk("count_held", 32'(instr_count), 32'd5);
`endif

        // Restart from HALTED with three wait states at PC 2.
        ack_force = 1'b0;
        wait_at[2] = 3;
        expect_issue(8'd0, 1, 0);
        expect_issue(8'd1, 1, 2);
        expect_issue(8'd2, 4, 5);
        expect_issue(8'd3, 1, 2);
        expect_issue(8'd4, 1, 2);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_pc", 32'(pc), 32'd0);
        chk("restart_req", 32'(bus.imem_req), 32'd1);
`ifdef FETCH_INSTR_COUNT_EN
        chk("count_cleared", 32'(instr_count), 32'd0);
`endif
        wait_drain(60);
        tick();
        chk("halt2_flag", 32'(halted), 32'd1);
        chk("halt2_pc", 32'(pc), 32'd4);

        // Jump, branch not taken, branch taken, then fall-through wrap at 8'hFF.
        wait_at[2] = 0;
        mem[0]     = 9'h1C0; ctl[0]     = 4'b0100; tgt[0]     = 8'h40; wait_at[0] = 5;
        mem[8'h40] = 9'h1A5; ctl[8'h40] = 4'b0010; tgt[8'h40] = 8'h80;
        mem[8'h41] = 9'h1B3; ctl[8'h41] = 4'b0011; tgt[8'h41] = 8'hFF;
        mem[8'hFF] = 9'h055; ctl[8'hFF] = 4'b0000; tgt[8'hFF] = 8'h10;
        expect_issue(8'h00, 6, 0);
        expect_issue(8'h40, 1, 2);
        expect_issue(8'h41, 1, 2);
        expect_issue(8'hFF, 1, 2);
        start = 1'b1; tick(); tick(); tick(); tick(); start = 1'b0;
        wait_drain(60);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_req", 32'(bus.imem_req), 32'd1);
        chk("wrap_addr", 32'(bus.imem_addr), 32'd0);

        // Asynchronous reset while a fetch is outstanding.
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(bus.imem_req), 32'd0);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_instr", 32'(instruction), 32'd0);
        chk("async_rst_pc", 32'(pc), 32'd0);
        chk("async_rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_INSTR_COUNT_EN
        chk("async_rst_count", 32'(instr_count), 32'd0);
`endif
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_no_fetch", 32'(bus.imem_req), 32'd0);
        chk("post_rst_pc", 32'(pc), 32'd0);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 9-bit CPU. It owns the program counter, reads instruction memory through a request/acknowledge handshake, and presents one instruction at a time to the control unit. It consumes the control unit's `branch`, `jmp_ctrl` and `done_ctrl` outputs to choose the next PC. It sits between instruction memory and the decode stage and is the producer end of the instruction interface.

## Interface
Parameters:
- `PC_WIDTH`, default 8: program counter and instruction-memory address width.
- `INSTR_WIDTH`, default 9: instruction word width.

Ports:
- `clock` — input, 1 bit: single clock. All state updates on the rising edge.
- `reset` — input, 1 bit: asynchronous, active-high.
- `start` — input, 1 bit: pulse that begins execution at PC 0. Honoured only in IDLE or HALTED.
- `imem_req` — output, 1 bit: instruction-memory read request.
- `imem_addr` — output, PC_WIDTH: read address; equals `pc`.
- `imem_ack` — input, 1 bit: memory read data is valid this cycle.
- `imem_rdata` — input, INSTR_WIDTH: instruction word; sampled when `imem_ack` is high.
- `instruction` — output, INSTR_WIDTH: registered instruction sent to the control unit.
- `instr_valid` — output, 1 bit: `instruction` is being issued this cycle.
- `branch` — input, 1 bit: from the control unit; instruction is beq or blt.
- `branch_cond` — input, 1 bit: ALU compare result; the branch is taken when this is high.
- `jmp_ctrl` — input, 1 bit: from the control unit; unconditional jump.
- `done_ctrl` — input, 1 bit: from the control unit; halt.
- `target_addr` — input, PC_WIDTH: branch or jump target, supplied by the external target lookup.
- `pc` — output, PC_WIDTH: current program counter.
- `halted` — output, 1 bit: high while in HALTED.

## Operation
The state machine has four states: IDLE, FETCH, ISSUE and HALTED.

- **IDLE** (reset state): all outputs are 0. When `start` is high, set `pc` to 0 and move to FETCH.
- **FETCH**:
  - `imem_req` is 1 and `imem_addr` equals `pc`.
  - Stay in FETCH until `imem_ack` is high.
  - On `imem_ack`, latch `imem_rdata` into `instruction` and move to ISSUE.
- **ISSUE**:
  - `instr_valid` is 1 for exactly one cycle.
  - The control-unit inputs are combinational from `instruction` and are sampled in this cycle.
  - Next-PC priority, highest first:
    1. `done_ctrl` high: go to HALTED; `pc` is unchanged.
    2. `jmp_ctrl` high: `pc` becomes `target_addr`; go to FETCH.
    3. `branch` and `branch_cond` both high: `pc` becomes `target_addr`; go to FETCH.
    4. Otherwise: `pc` becomes `pc + 1`, modulo 2^PC_WIDTH, so PC 2^PC_WIDTH−1 wraps to 0; go to FETCH.
- **HALTED**:
  - `halted` is 1.
  - `pc` and `instruction` hold their values.
  - When `start` is high, set `pc` to 0, clear `halted`, and move to FETCH.

Boundary rules:
- `imem_ack` is ignored outside FETCH.
- `start` is ignored in FETCH and ISSUE.
- `done_ctrl` together with `jmp_ctrl` means halt.
- `branch` with `branch_cond` low falls through to `pc + 1`.
- X values on the control inputs outside ISSUE have no effect.

## Timing
- **Reset values:** every output is 0, including `pc`, `instruction`, `instr_valid`, `imem_req` and `halted`. `imem_req` drops in the same instant `reset` rises, with no clock needed; the state is IDLE.
- **Start:** `start` sampled high at edge N gives `imem_req` high from cycle N+1.
- **Fetch latency:** ack sampled at edge M gives `instr_valid` high in cycle M+1. The new `pc` and `imem_req` appear in cycle M+2.
- **Throughput:** with a zero-wait memory (`imem_ack` tied high), one instruction issues every 2 cycles.
- **Handshake:** `imem_addr` is stable for as long as `imem_req` is high. The memory may hold `imem_ack` low for any number of cycles.
- **Reset mid-operation:** an in-flight fetch is abandoned; the next fetch begins only after a new `start`.

## Configuration
- **`FETCH_INSTR_COUNT_EN` defined:** adds the output port `instr_count`, 16 bits.
  - It is cleared by `reset` and by an accepted `start`.
  - It increments once per `instr_valid` cycle and saturates at 16'hFFFF.
  - It holds its value in HALTED.
- **Not defined:** the port and the counter logic are absent. The rest of the behaviour is identical.

## Test plan
- **Sequential fetch:** reset, then pulse `start`. Memory holds add words (9'h000) at PCs 0..3 and zero-wait ack. Required: `instr_valid` every second cycle, `pc` goes 0→1→2→3, and `imem_addr` matches `pc`.
- **Wait states:** delay `imem_ack` 3 cycles at PC 2. Required: `imem_req` is held with `imem_addr` = 2 for 4 cycles, and `instr_valid` is not asserted early.
- **Jump and branch:**
  - Jump (9'h1C0 with `jmp_ctrl` = 1, `target_addr` = 8'h40): `pc` becomes 8'h40.
  - Branch not taken (`branch` = 1, `branch_cond` = 0): `pc` becomes `pc + 1`.
  - Branch taken (`branch_cond` = 1): `pc` becomes `target_addr`.
- **Halt:** issue 9'h0E2 with `done_ctrl` = 1 while `jmp_ctrl` = 1. Required: HALTED, `halted` = 1, and `pc` unchanged. A later `start` restarts at PC 0.
- **Wrap and reset:** fall-through at PC 8'hFF gives `pc` = 8'h00. Asserting `reset` during FETCH drops `imem_req` immediately and returns all outputs to 0.
- **Counter (`FETCH_INSTR_COUNT_EN` defined):** issue 5 instructions and halt. Required: `instr_count` = 5 and held; it clears to 0 on restart.
